mm_job_scheduler: RTL and testbench
===================================

// Module: mm_job_scheduler
// PURPOSE
//   Shares one compute_unit (16x16 int8 matmul engine: single start pulse in, one-cycle done out)
//   between NUM_REQ requesters. Round-robin arbitration, one job in flight, start pulse issued,
//   runtime measured, completion returned on a valid/ready response port with requester id and
//   tag. A watchdog flags jobs that overrun TIMEOUT and quarantines the engine until it finishes.
// PARAMETERS
//   NUM_REQ   4     number of requesters (>=2)
//   TAG_W     4     per-job tag width, echoed on response
//   TIMEOUT   4095  max cycles from cu_start to cu_done before error (>= 600; nominal job ~530)
//   ID_W      $clog2(NUM_REQ)   derived, requester index width
//   CYC_W     $clog2(TIMEOUT+1) derived, cycle counter width
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   req_valid  in   NUM_REQ        per-requester job request
//   req_tag    in   NUM_REQ*TAG_W  per-requester tag, slice i = [i*TAG_W +: TAG_W]
//   req_ready  out  NUM_REQ        one-hot grant; transfer when req_valid[i] & req_ready[i]
//   cu_start   out  1              one-cycle start pulse to compute_unit
//   cu_done    in   1              one-cycle completion pulse from compute_unit
//   rsp_valid  out  1              completion record valid, held until rsp_ready
//   rsp_ready  in   1              consumer accepts record
//   rsp_id     out  ID_W           requester index of completed job
//   rsp_tag    out  TAG_W          tag of completed job
//   rsp_err    out  1              1 = watchdog timeout, result in bram_c invalid
//   rsp_cycles out  CYC_W          cycles from cu_start to cu_done (TIMEOUT on error)
//   busy       out  1              state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, rr pointer 0, all outputs 0, late_done flag 0.
//   FSM (states in package enum):
//   - IDLE: req_ready = one-hot rr winner among req_valid (comb, this state only). On grant latch
//     id/tag, rr pointer <= winner+1 mod NUM_REQ, -> START. No req_valid: stay, req_ready=0.
//   - START: cu_start=1 (exactly one cycle), cycle counter <= 1, -> RUN.
//   - RUN: counter +1 per cycle. cu_done -> RESP, err=0, rsp_cycles=counter.
//     counter==TIMEOUT and no cu_done -> RESP, err=1, rsp_cycles=TIMEOUT. cu_done wins if both.
//   - RESP: rsp_valid=1; id/tag/err/cycles stable until rsp_ready. On accept: err=0 -> IDLE;
//     err=1 -> IDLE if late_done set, else DRAIN. cu_done here with err=1 sets late_done.
//   - DRAIN: wait for cu_done (engine cannot be aborted), then -> IDLE; no grants meanwhile.
//   - Unreachable encodings -> IDLE.
//   Latency: grant to cu_start 1 cycle; cu_done to rsp_valid 1 cycle; rsp accept to next grant
//   1 cycle (IDLE re-arbitrates). Max throughput one job per (job time + 3) cycles.
//   cu_done in IDLE/START ignored. req_valid deasserted before grant: no job, no pointer change.
//   Counter saturates at TIMEOUT, never wraps. late_done cleared on leaving RESP/DRAIN.
//   rst mid-job: FSM to IDLE, pending response dropped; system reset also resets compute_unit.
// STRUCTURE
//   Package mm_sched_pkg: sched_state_t enum {IDLE,START,RUN,RESP,DRAIN}; job_rec_t struct
//   {id, tag, err, cycles}; default NUM_REQ/TAG_W/TIMEOUT constants.
//   Sub-module rr_arbiter #(N): req vector, rr pointer -> one-hot grant, grant index. Pure comb;
//   pointer register lives in the scheduler.
// TESTING
//   1 single job: req_valid=0001 tag=5, done 530 cyc after start -> one cu_start, rsp id=0
//     tag=5 err=0 cycles=530.
//   2 fairness: req_valid=1111 held -> grants in order 0,1,2,3,0; each one-hot, one per job.
//   3 backpressure: rsp_ready=0 for 20 cycles -> rsp fields stable, no new req_ready/cu_start.
//   4 timeout: no cu_done -> rsp err=1 cycles=4095 at cycle 4096; accept, DRAIN; done at 5000
//     -> IDLE next cycle; no grant before.
//   5 race: cu_done on same cycle counter hits TIMEOUT -> err=0, cycles=4095.
//   6 reset mid-RUN (rst high 1 cycle) -> next cycle all outputs 0, busy=0, rr pointer 0.

Source files
------------

// File: rtl/mm_job_scheduler_pkg.sv
// Shared types for the matmul job scheduler:
// FSM states, completion record and default sizing.
package mm_sched_pkg;

  localparam int NUM_REQ_D = 4;
  localparam int TAG_W_D   = 4;
  localparam int TIMEOUT_D = 4095;
  localparam int ID_W_D    = $clog2(NUM_REQ_D);
  localparam int CYC_W_D   = $clog2(TIMEOUT_D + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    RESP,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [ID_W_D-1:0]  id;
    logic [TAG_W_D-1:0] tag;
    logic               err;
    logic [CYC_W_D-1:0] cycles;
  } job_rec_t;

endpackage

// File: rtl/mm_job_scheduler_if.sv
// Request, compute-unit and response bundle
// between requesters, scheduler and engine.
interface mm_job_scheduler_if
  import mm_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int TAG_W   = TAG_W_D,
  parameter int TIMEOUT = TIMEOUT_D
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CYC_W = $clog2(TIMEOUT + 1);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     cu_start;
  logic                     cu_done;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [TAG_W-1:0]         rsp_tag;
  logic                     rsp_err;
  logic [CYC_W-1:0]         rsp_cycles;

  modport slave (
    input  req_valid, req_tag, cu_done, rsp_ready,
    output req_ready, cu_start, rsp_valid,
    output rsp_id, rsp_tag, rsp_err, rsp_cycles
  );

  modport master (
    output req_valid, req_tag, cu_done, rsp_ready,
    input  req_ready, cu_start, rsp_valid,
    input  rsp_id, rsp_tag, rsp_err, rsp_cycles
  );

endinterface

// File: rtl/mm_job_scheduler_arb.sv
// Round-robin picker: first requester at or
// after ptr_i, wrapping; purely combinational.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW:0] pos;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req_i[pos[IW-1:0]]) begin
        found              = 1'b1;
        idx_o              = pos[IW-1:0];
        gnt_o[pos[IW-1:0]] = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/mm_job_scheduler.sv
// Shares one matmul engine among requesters:
// RR grant, start pulse, runtime, watchdog.
module mm_job_scheduler
  import mm_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int TAG_W   = TAG_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic             clk,
  input  logic             rst,
  mm_job_scheduler_if.slave bus,
  output logic             busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CYC_W = $clog2(TIMEOUT + 1);
  localparam logic [CYC_W-1:0] TMO  = CYC_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  LAST = ID_W'(NUM_REQ - 1);

  sched_state_t state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  job_rec_t         rec_q, rec_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             late_q, late_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      rec_q   <= '0;
      cnt_q   <= '0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    rec_d   = rec_q;
    cnt_d   = cnt_q;
    late_d  = late_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          rec_d.id     = gnt_idx;
          rec_d.tag    = bus.req_tag[gnt_idx*TAG_W +: TAG_W];
          rec_d.err    = 1'b0;
          rec_d.cycles = '0;
          rr_d    = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CYC_W'(1);
        state_d = RUN;
      end
      RUN: begin
        if (bus.cu_done) begin
          rec_d.err    = 1'b0;
          rec_d.cycles = cnt_q;
          state_d      = RESP;
        end else if (cnt_q == TMO) begin
          rec_d.err    = 1'b1;
          rec_d.cycles = TMO;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.cu_done && rec_q.err) late_d = 1'b1;
        if (bus.rsp_ready) begin
          late_d = 1'b0;
          // a late done landing on the accept cycle also frees the engine
          if (rec_q.err && !(late_q || bus.cu_done))
            state_d = DRAIN;
          else
            state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.cu_done) begin
          late_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE) bus.req_ready = gnt;
    bus.cu_start  = (state_q == START);
    bus.rsp_valid = (state_q == RESP);
  end

  assign bus.rsp_id     = rec_q.id;
  assign bus.rsp_tag    = rec_q.tag;
  assign bus.rsp_err    = rec_q.err;
  assign bus.rsp_cycles = rec_q.cycles;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Scoreboard bench for mm_job_scheduler with a
// job-level reference model and engine model.
`timescale 1ns/1ps
module tb_mm_job_scheduler;
  import mm_sched_pkg::*;

  localparam int N    = NUM_REQ_D;
  localparam int TW   = TAG_W_D;
  localparam int TO   = TIMEOUT_D;
  localparam int IW   = $clog2(N);
  localparam int CW   = $clog2(TO + 1);
  localparam int RW   = IW + TW + 1 + CW;
  localparam int HOLD = 20;

  typedef struct {int rq; int tag; int lat;} job_t;
  typedef struct {int id; int tag; int err; int cyc;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  mm_job_scheduler_if #(.NUM_REQ(N), .TAG_W(TW), .TIMEOUT(TO)) bus ();

  mm_job_scheduler #(.NUM_REQ(N), .TAG_W(TW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  job_t pend[$];
  exp_t sb[$];
  int   ptr = 0;
  int   outstanding = 0;
  int   due = 0;
  bit   eng_busy = 1'b0;
  int   done_at = -1;
  int   lat_next = 0;
  bit   start_due = 1'b0;
  int   rdy_mode = 0;
  int   hold_cnt = 0;
  bit   rand_gap = 1'b0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int head_idx(int r);
    foreach (pend[j]) if (pend[j].rq == r) return j;
    return -1;
  endfunction

  task automatic push(int r, int t, int l);
    job_t j;
    j.rq = r; j.tag = t; j.lat = l;
    pend.push_back(j);
  endtask

  task automatic wait_idle(int lim);
    int n;
    n = 0;
    while ((pend.size() > 0 || outstanding > 0 || eng_busy) && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, want idle", n);
    end
  endtask

  // Driver: requesters, consumer and compute-unit model; predicts grants.
  initial begin : driver
    logic [N-1:0]    vm;
    logic [N*TW-1:0] tg;
    int   win;
    int   h;
    bit   dn;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      vm = '0;
      tg = '0;
      for (int i = 0; i < N; i++) begin
        h = head_idx(i);
        if (h >= 0) tg[i*TW +: TW] = TW'(pend[h].tag);
        if (h >= 0 && !rst && !(rand_gap && $urandom_range(3) == 0)) vm[i] = 1'b1;
      end
      dn = eng_busy && (cyc == done_at);
      bus.req_valid = vm;
      bus.req_tag   = tg;
      bus.cu_done   = dn;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(1));
        default: bus.rsp_ready = (hold_cnt >= HOLD);
      endcase
      #1;
      win = -1;
      if (!rst && outstanding == 0 && !eng_busy)
        for (int k = 0; k < N; k++)
          if (win < 0 && vm[(ptr + k) % N]) win = (ptr + k) % N;
      chk("req_ready", bus.req_ready, (win < 0) ? 0 : (1 << win));
      chk("cu_start", bus.cu_start, start_due);
      chk("busy", busy, (outstanding > 0 || eng_busy));
      if (bus.rsp_valid) hold_cnt = bus.rsp_ready ? 0 : hold_cnt + 1;
      if (start_due) done_at = cyc + lat_next;
      start_due = 1'b0;
      if (dn) eng_busy = 1'b0;
      if (win >= 0) begin
        h     = head_idx(win);
        e.id  = win;
        e.tag = pend[h].tag;
        e.err = (pend[h].lat > TO) ? 1 : 0;
        e.cyc = (pend[h].lat > TO) ? TO : pend[h].lat;
        sb.push_back(e);
        due         = cyc + 2 + e.cyc;
        outstanding = outstanding + 1;
        eng_busy    = 1'b1;
        start_due   = 1'b1;
        lat_next    = pend[h].lat;
        ptr         = (win + 1) % N;
        pend.delete(h);
      end
      @(negedge clk);
      #1;
      if (rst) begin
        sb.delete();
        outstanding = 0;
        eng_busy    = 1'b0;
        start_due   = 1'b0;
        ptr         = 0;
        hold_cnt    = 0;
      end
    end
  end

  // Monitor: response port against the scoreboard.
  initial begin : monitor
    logic [RW-1:0] got;
    logic [RW-1:0] want;
    forever begin
      @(posedge clk);
      #3;
      chk("rsp_valid", bus.rsp_valid, (outstanding > 0 && cyc >= due));
      if (bus.rsp_valid && sb.size() > 0) begin
        got  = {bus.rsp_id, bus.rsp_tag, bus.rsp_err, bus.rsp_cycles};
        want = {IW'(sb[0].id), TW'(sb[0].tag), 1'(sb[0].err), CW'(sb[0].cyc)};
        chk("rsp_rec", got, want);
        if (bus.rsp_ready) begin
          void'(sb.pop_front());
          outstanding = outstanding - 1;
        end
      end
    end
  end

  initial begin : main
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.cu_done   = 1'b0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.req_ready, bus.cu_start, bus.rsp_valid, bus.rsp_id,
                     bus.rsp_tag, bus.rsp_err, bus.rsp_cycles, busy}, 0);
    rst = 1'b0;

    push(0, 5, 530);
    wait_idle(2000);

    rdy_mode = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, (i * 3 + r + 1) % 16, 5 + i);
    wait_idle(1000);
    rdy_mode = 0;

    push(0, 9, 5000);
    repeat (10) @(negedge clk);
    push(2, 3, 12);
    wait_idle(12000);

    push(1, 6, TO);
    wait_idle(6000);

    rdy_mode = 2;
    push(3, 12, TO + 5);
    push(0, 1, 7);
    wait_idle(6000);

    rdy_mode = 1;
    rand_gap = 1'b1;
    for (int j = 0; j < 40; j++) begin
      push($urandom_range(N - 1), $urandom_range(15), $urandom_range(40, 1));
      if ($urandom_range(2) == 0) repeat ($urandom_range(30)) @(negedge clk);
    end
    wait_idle(8000);
    rand_gap = 1'b0;
    rdy_mode = 0;

    push(2, 7, 300);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", {bus.req_ready, bus.cu_start, bus.rsp_valid, bus.rsp_id,
                    bus.rsp_tag, bus.rsp_err, bus.rsp_cycles, busy}, 0);
    push(3, 4, 10);
    push(1, 2, 10);
    wait_idle(500);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
